// File: rtl/dma_priority_ctrl.sv
// dma_priority_ctrl
//   Channel arbiter and bus-hold sequencer for a 4-channel DMA controller.
//   It qualifies channel requests and raises HRQ. When HLDA arrives it
//   resolves priority and drives DACK for the winning channel. It then
//   reports the granted channel and releases the bus when timing control
//   pulses xfer_done.
//
// Optional build macro:
//   DMA_DREQ_SYNC_EN - route DREQ through a 2-flop synchronizer. This makes
//                      the DREQ-to-HRQ latency 3 cycles instead of 1.
//
// Ports:
//   CLK, RESET   clock and synchronous active-high reset
//   DREQ[3:0]    request pins, active level selected by dreq_pol
//   HLDA         hold acknowledge from CPU
//   HRQ          hold request to CPU (registered)
//   DACK[3:0]    acknowledge pins, active level selected by dack_pol (registered)
//   mask[3:0]    1 = ignore that channel's DREQ
//   sw_req[3:0]  software requests, not affected by mask
//   ctrl_dis     blocks new hold requests from IDLE
//   rot_pri      0 = fixed priority (ch0 highest), 1 = rotating priority
//   dreq_pol     0 = DREQ active-high, 1 = active-low
//   dack_pol     0 = DACK active-low, 1 = active-high
//   xfer_done    single-cycle end-of-service pulse
//   grant_vld    a channel is being serviced (registered)
//   grant_ch     index of the serviced channel (registered)
module dma_priority_ctrl #(
    parameter int NUM_CH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    input  logic [NUM_CH-1:0] mask,
    input  logic [NUM_CH-1:0] sw_req,
    input  logic              ctrl_dis,
    input  logic              rot_pri,
    input  logic              dreq_pol,
    input  logic              dack_pol,
    input  logic              xfer_done,
    output logic              grant_vld,
    output logic [1:0]        grant_ch
);

    typedef enum logic [1:0] {IDLE, HOLD_REQ, SERVICE, RELEASE} state_t;

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] dreq_q;
    logic [NUM_CH-1:0] eff;
    logic [NUM_CH-1:0] dack_act, act_nxt;
    logic [1:0]        ptr, ptr_nxt;
    logic [1:0]        win;
    logic              hrq_nxt, gv_nxt;
    logic [1:0]        gc_nxt;

    // Search starts at base and wraps modulo 4. The first requesting
    // channel wins.
    function automatic logic [1:0] arbitrate(input logic [NUM_CH-1:0] req,
                                             input logic [1:0] base);
        logic [1:0] idx;
        logic [1:0] w;
        logic       found;
        w     = base;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = base + 2'(k);
            if (!found && req[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

`ifdef DMA_DREQ_SYNC_EN
    logic [NUM_CH-1:0] dreq_s1, dreq_s2;

    // The synchronizer resets to the inactive level, so no phantom request
    // appears coming out of reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            dreq_s1 <= {NUM_CH{dreq_pol}};
            dreq_s2 <= {NUM_CH{dreq_pol}};
        end else begin
            dreq_s1 <= DREQ;
            dreq_s2 <= dreq_s1;
        end
    end
    assign dreq_q = dreq_s2;
`else
    assign dreq_q = DREQ;
`endif

    assign eff = ((dreq_q ^ {NUM_CH{dreq_pol}}) & ~mask) | sw_req;
    // Fixed mode always searches from channel 0, whatever the pointer holds.
    assign win = arbitrate(eff, rot_pri ? ptr : 2'd0);

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (|eff && !ctrl_dis) state_nxt = HOLD_REQ;
            HOLD_REQ: begin
                if (eff == '0)    state_nxt = IDLE;
                else if (HLDA)    state_nxt = SERVICE;
            end
            // CPU preemption takes precedence over a coincident xfer_done.
            SERVICE: begin
                if (!HLDA)         state_nxt = IDLE;
                else if (xfer_done) state_nxt = RELEASE;
            end
            RELEASE:  if (!HLDA) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        hrq_nxt = HRQ;
        act_nxt = dack_act;
        gv_nxt  = grant_vld;
        gc_nxt  = grant_ch;
        ptr_nxt = ptr;
        case (state)
            IDLE: begin
                hrq_nxt = |eff && !ctrl_dis;
                act_nxt = '0;
                gv_nxt  = 1'b0;
            end
            HOLD_REQ: begin
                if (eff == '0) begin
                    hrq_nxt = 1'b0;
                end else if (HLDA) begin
                    act_nxt = NUM_CH'(1) << win;
                    gv_nxt  = 1'b1;
                    gc_nxt  = win;
                end
            end
            SERVICE: begin
                if (!HLDA) begin
                    hrq_nxt = 1'b0;
                    act_nxt = '0;
                    gv_nxt  = 1'b0;
                end else if (xfer_done) begin
                    hrq_nxt = 1'b0;
                    act_nxt = '0;
                    gv_nxt  = 1'b0;
                    ptr_nxt = rot_pri ? grant_ch + 2'd1 : 2'd0;
                end
            end
            RELEASE: begin
                hrq_nxt = 1'b0;
                act_nxt = '0;
                gv_nxt  = 1'b0;
            end
            default: begin
                hrq_nxt = 1'b0;
                act_nxt = '0;
                gv_nxt  = 1'b0;
            end
        endcase
    end

    // Output registers. DACK is re-encoded every cycle, so a dack_pol change
    // shows up on the next edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            HRQ       <= 1'b0;
            dack_act  <= '0;
            DACK      <= dack_pol ? '0 : '1;
            grant_vld <= 1'b0;
            grant_ch  <= 2'd0;
            ptr       <= 2'd0;
        end else begin
            HRQ       <= hrq_nxt;
            dack_act  <= act_nxt;
            DACK      <= dack_pol ? act_nxt : ~act_nxt;
            grant_vld <= gv_nxt;
            grant_ch  <= gc_nxt;
            ptr       <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_dma_priority_ctrl.sv
module tb_dma_priority_ctrl;

`ifdef DMA_DREQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       CLK = 1'b0;
    logic       RESET, HLDA, HRQ, ctrl_dis, rot_pri, dreq_pol, dack_pol, xfer_done, grant_vld;
    logic [3:0] DREQ, DACK, mask, sw_req;
    logic [1:0] grant_ch;

    int total   = 0;
    int pass_cnt = 0;

    always #5 CLK = ~CLK;

    dma_priority_ctrl #(.NUM_CH(4)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .HRQ(HRQ), .DACK(DACK),
        .mask(mask), .sw_req(sw_req), .ctrl_dis(ctrl_dis), .rot_pri(rot_pri),
        .dreq_pol(dreq_pol), .dack_pol(dack_pol), .xfer_done(xfer_done),
        .grant_vld(grant_vld), .grant_ch(grant_ch)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Ends the current service, drops all requests and lets the bus go idle.
    task automatic finish_service();
        xfer_done = 1'b1;
        DREQ      = {4{dreq_pol}};
        sw_req    = 4'b0000;
        step(1);
        xfer_done = 1'b0;
        HLDA      = 1'b0;
        step(3);
    endtask

    task automatic test_reset();
        RESET = 1'b1; DREQ = 4'b0000; HLDA = 1'b0; mask = 4'b0000; sw_req = 4'b0000;
        ctrl_dis = 1'b0; rot_pri = 1'b0; dreq_pol = 1'b0; dack_pol = 1'b0; xfer_done = 1'b0;
        step(2);
        total++; if (HRQ !== 1'b0) $display("FAIL reset_hrq: got %b want 0", HRQ); else pass_cnt++;
        total++; if (DACK !== 4'hF) $display("FAIL reset_dack: got %b want 1111", DACK); else pass_cnt++;
        total++; if (grant_vld !== 1'b0) $display("FAIL reset_gv: got %b want 0", grant_vld); else pass_cnt++;
        total++; if (grant_ch !== 2'd0) $display("FAIL reset_gc: got %0d want 0", grant_ch); else pass_cnt++;
        RESET = 1'b0;
        step(1);
    endtask

    task automatic test_fixed();
        DREQ = 4'b1010;
        step(LAT);
        total++; if (HRQ !== 1'b1) $display("FAIL fixed_hrq: got %b want 1", HRQ); else pass_cnt++;
        total++; if (DACK !== 4'hF) $display("FAIL fixed_dack_pre: got %b want 1111", DACK); else pass_cnt++;
        HLDA = 1'b1;
        step(1);
        total++; if (DACK !== 4'b1101) $display("FAIL fixed_dack: got %b want 1101", DACK); else pass_cnt++;
        total++; if (grant_ch !== 2'd1) $display("FAIL fixed_gc: got %0d want 1", grant_ch); else pass_cnt++;
        total++; if (grant_vld !== 1'b1) $display("FAIL fixed_gv: got %b want 1", grant_vld); else pass_cnt++;
        DREQ = 4'b1011;
        step(LAT + 1);
        total++; if (grant_ch !== 2'd1) $display("FAIL fixed_no_rearb: got %0d want 1", grant_ch); else pass_cnt++;
        xfer_done = 1'b1; DREQ = 4'b0000;
        step(1);
        xfer_done = 1'b0;
        total++; if (HRQ !== 1'b0) $display("FAIL fixed_done_hrq: got %b want 0", HRQ); else pass_cnt++;
        total++; if (DACK !== 4'hF) $display("FAIL fixed_done_dack: got %b want 1111", DACK); else pass_cnt++;
        total++; if (grant_vld !== 1'b0) $display("FAIL fixed_done_gv: got %b want 0", grant_vld); else pass_cnt++;
        HLDA = 1'b0;
        step(3);
    endtask

    task automatic test_rotating();
        rot_pri = 1'b1;
        DREQ = 4'b0100;
        step(LAT);
        HLDA = 1'b1;
        step(1);
        total++; if (grant_ch !== 2'd2) $display("FAIL rot_first_gc: got %0d want 2", grant_ch); else pass_cnt++;
        xfer_done = 1'b1; DREQ = 4'b0000;
        step(1);
        xfer_done = 1'b0; DREQ = 4'b1111;
        step(3);
        total++; if (HRQ !== 1'b0) $display("FAIL rot_release_hold: got %b want 0", HRQ); else pass_cnt++;
        HLDA = 1'b0;
        step(1);
        total++; if (HRQ !== 1'b0) $display("FAIL rot_hrq_min_low: got %b want 0", HRQ); else pass_cnt++;
        step(1);
        total++; if (HRQ !== 1'b1) $display("FAIL rot_hrq_again: got %b want 1", HRQ); else pass_cnt++;
        HLDA = 1'b1;
        step(1);
        total++; if (grant_ch !== 2'd3) $display("FAIL rot_second_gc: got %0d want 3", grant_ch); else pass_cnt++;
        xfer_done = 1'b1;
        step(1);
        xfer_done = 1'b0; HLDA = 1'b0;
        step(2);
        HLDA = 1'b1;
        step(1);
        total++; if (grant_ch !== 2'd0) $display("FAIL rot_third_gc: got %0d want 0", grant_ch); else pass_cnt++;
        finish_service();
    endtask

    task automatic test_preempt();
        // Pointer is 1 here after channel 0 was serviced in rotating mode.
        DREQ = 4'b0010;
        step(LAT);
        HLDA = 1'b1;
        step(1);
        total++; if (DACK !== 4'b1101) $display("FAIL pre_dack: got %b want 1101", DACK); else pass_cnt++;
        HLDA = 1'b0; DREQ = 4'b0000;
        step(1);
        total++; if (DACK !== 4'hF) $display("FAIL pre_drop_dack: got %b want 1111", DACK); else pass_cnt++;
        total++; if (grant_vld !== 1'b0) $display("FAIL pre_drop_gv: got %b want 0", grant_vld); else pass_cnt++;
        total++; if (HRQ !== 1'b0) $display("FAIL pre_drop_hrq: got %b want 0", HRQ); else pass_cnt++;
        step(4);
        DREQ = 4'b1111;
        step(LAT);
        HLDA = 1'b1;
        step(1);
        total++; if (grant_ch !== 2'd1) $display("FAIL pre_ptr_kept: got %0d want 1", grant_ch); else pass_cnt++;
        rot_pri = 1'b0;
        finish_service();
    endtask

    task automatic test_mask();
        mask = 4'b0001; DREQ = 4'b0001;
        step(LAT + 2);
        total++; if (HRQ !== 1'b0) $display("FAIL mask_hrq: got %b want 0", HRQ); else pass_cnt++;
        sw_req = 4'b0001;
        step(1);
        total++; if (HRQ !== 1'b1) $display("FAIL swreq_hrq: got %b want 1", HRQ); else pass_cnt++;
        HLDA = 1'b1;
        step(1);
        total++; if (grant_ch !== 2'd0) $display("FAIL swreq_gc: got %0d want 0", grant_ch); else pass_cnt++;
        total++; if (DACK !== 4'b1110) $display("FAIL swreq_dack: got %b want 1110", DACK); else pass_cnt++;
        finish_service();
        mask = 4'b0000;
        ctrl_dis = 1'b1; DREQ = 4'b0001;
        step(LAT + 2);
        total++; if (HRQ !== 1'b0) $display("FAIL ctrl_dis_hrq: got %b want 0", HRQ); else pass_cnt++;
        DREQ = 4'b0000;
        step(3);
        ctrl_dis = 1'b0;
        step(1);
    endtask

    task automatic test_withdraw();
        DREQ = 4'b1000;
        step(LAT);
        total++; if (HRQ !== 1'b1) $display("FAIL wd_hrq_up: got %b want 1", HRQ); else pass_cnt++;
        DREQ = 4'b0000;
        step(LAT);
        total++; if (HRQ !== 1'b0) $display("FAIL wd_hrq_down: got %b want 0", HRQ); else pass_cnt++;
        HLDA = 1'b1;
        step(1);
        total++; if (DACK !== 4'hF) $display("FAIL wd_dack: got %b want 1111", DACK); else pass_cnt++;
        total++; if (grant_vld !== 1'b0) $display("FAIL wd_gv: got %b want 0", grant_vld); else pass_cnt++;
        HLDA = 1'b0;
        step(2);
    endtask

    task automatic test_reset_in_service();
        DREQ = 4'b0100;
        step(LAT);
        HLDA = 1'b1;
        step(1);
        total++; if (grant_vld !== 1'b1) $display("FAIL rst_svc_gv_pre: got %b want 1", grant_vld); else pass_cnt++;
        RESET = 1'b1;
        step(1);
        total++; if (HRQ !== 1'b0) $display("FAIL rst_svc_hrq: got %b want 0", HRQ); else pass_cnt++;
        total++; if (DACK !== 4'hF) $display("FAIL rst_svc_dack: got %b want 1111", DACK); else pass_cnt++;
        total++; if (grant_vld !== 1'b0) $display("FAIL rst_svc_gv: got %b want 0", grant_vld); else pass_cnt++;
        total++; if (grant_ch !== 2'd0) $display("FAIL rst_svc_gc: got %0d want 0", grant_ch); else pass_cnt++;
        RESET = 1'b0; DREQ = 4'b0000;
        step(2);
        total++; if (HRQ !== 1'b0) $display("FAIL rst_svc_idle: got %b want 0", HRQ); else pass_cnt++;
        HLDA = 1'b0;
        step(1);
    endtask

    task automatic test_polarity();
        dreq_pol = 1'b1; dack_pol = 1'b1; DREQ = 4'hF; RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        total++; if (DACK !== 4'h0) $display("FAIL pol_reset_dack: got %b want 0000", DACK); else pass_cnt++;
        step(2);
        total++; if (HRQ !== 1'b0) $display("FAIL pol_idle_hrq: got %b want 0", HRQ); else pass_cnt++;
        DREQ = 4'b1110;
        step(LAT);
        total++; if (HRQ !== 1'b1) $display("FAIL pol_hrq: got %b want 1", HRQ); else pass_cnt++;
        HLDA = 1'b1;
        step(1);
        total++; if (DACK !== 4'b0001) $display("FAIL pol_dack_hi: got %b want 0001", DACK); else pass_cnt++;
        dack_pol = 1'b0;
        step(1);
        total++; if (DACK !== 4'b1110) $display("FAIL pol_dack_flip: got %b want 1110", DACK); else pass_cnt++;
        finish_service();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rotating();
        test_preempt();
        test_mask();
        test_withdraw();
        test_reset_in_service();
        test_polarity();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/dma_priority_ctrl.md
Name: dma_priority_ctrl

Overview:
- Channel arbiter and bus-hold sequencer for the 4-channel DMA controller.
- Sits between the DREQ/DACK/HRQ/HLDA pins and the timing-control block.
- Qualifies channel requests, raises HRQ, resolves priority when HLDA arrives and drives DACK for the winner.
- Reports the granted channel to the datapath, and releases the bus when timing control signals end of service.

Parameters:
- NUM_CH, 4: number of DMA channels. The design is fixed at 4; the parameter is used only for vector widths.

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous reset, active-high
- DREQ  input  4  channel request pins; level set by dreq_pol
- HLDA  input  1  hold acknowledge from CPU
- HRQ  output  1  hold request to CPU
- DACK  output  4  channel acknowledge pins; level set by dack_pol
- mask  input  4  per-channel mask; 1 = ignore DREQ
- sw_req  input  4  software request bits; bypass mask
- ctrl_dis  input  1  controller disable (command register)
- rot_pri  input  1  0 = fixed priority, 1 = rotating priority
- dreq_pol  input  1  0 = DREQ active-high, 1 = active-low
- dack_pol  input  1  0 = DACK active-low, 1 = active-high
- xfer_done  input  1  one-cycle pulse from timing control: service complete (single transfer end, TC or EOP)
- grant_vld  output  1  a channel is currently being serviced
- grant_ch  output  2  index of serviced channel

Behaviour:
- Effective request: eff[i] = ((DREQ[i] ^ dreq_pol) & ~mask[i]) | sw_req[i].
- Reset values:
  - HRQ = 0, grant_vld = 0, grant_ch = 0.
  - DACK = all inactive (4'hF when dack_pol = 0, 4'h0 when dack_pol = 1).
  - Priority pointer = 0; state = IDLE.
- FSM states: IDLE, HOLD_REQ, SERVICE, RELEASE. All outputs are registered.
- IDLE:
  - If |eff and !ctrl_dis: next cycle HRQ = 1, go to HOLD_REQ. Latency DREQ edge to HRQ = 1 cycle.
- HOLD_REQ:
  - HRQ held at 1.
  - If eff == 0 before HLDA: HRQ = 0 next cycle, return to IDLE (request withdrawn).
  - On HLDA = 1 with |eff: arbitrate on the current-cycle eff. Next cycle: DACK[win] active, grant_vld = 1, grant_ch = win, go to SERVICE. Latency HLDA to DACK = 1 cycle.
  - ctrl_dis does not abort HOLD_REQ.
- Arbitration:
  - Fixed mode: channel 0 highest, channel 3 lowest.
  - Rotating mode: pointer p is the highest channel, then p+1, … mod 4.
  - The winner is latched and is not re-arbitrated during SERVICE, even if a higher-priority request arrives.
- SERVICE:
  - On xfer_done: next cycle DACK inactive, grant_vld = 0, HRQ = 0, go to RELEASE.
  - If rot_pri = 1, on the same edge p = (grant_ch + 1) mod 4.
  - If rot_pri = 0, p forced to 0.
- RELEASE:
  - Wait for HLDA = 0, then go to IDLE.
  - A new HRQ is not raised before the cycle after HLDA is seen low. Minimum HRQ low time = 1 cycle.
- HLDA dropped during SERVICE (CPU preemption):
  - Next cycle DACK inactive, grant_vld = 0, HRQ = 0, go to IDLE.
  - No pointer rotation.
- xfer_done outside SERVICE: ignored.
- Polarity: a change of dack_pol takes effect on the next registered update of DACK.
- RESET asserted in any state: all outputs take reset values on the next edge, regardless of HLDA.

Optional Feature:
- Macro: DMA_DREQ_SYNC_EN.
- Defined:
  - DREQ passes through a 2-flop synchronizer before the eff computation.
  - DREQ-to-HRQ latency = 3 cycles.
  - Synchronizer flops reset to the inactive level for the current dreq_pol.
- Undefined:
  - DREQ is used directly.
  - DREQ-to-HRQ latency = 1 cycle.
- sw_req and mask are never synchronized in either case.

Test Plan:
- Fixed priority, dreq_pol = 0, dack_pol = 0, DREQ = 4'b1010 → HRQ = 1 after 1 cycle. HLDA = 1 → next cycle DACK = 4'b1101, grant_ch = 1. xfer_done → HRQ = 0, DACK = 4'hF.
- Rotating priority: service ch2, then DREQ = 4'b1111 → next grant is ch3, then ch0 (pointer = 3, then 0).
- Masking: mask = 4'b0001 with DREQ[0] = 1 → HRQ stays 0. Same with sw_req = 4'b0001 → HRQ = 1, grant_ch = 0.
- DREQ withdrawn in HOLD_REQ before HLDA → HRQ = 0 next cycle, DACK never asserted.
- HLDA dropped mid-SERVICE on ch1 → DACK inactive next cycle, grant_vld = 0, pointer unchanged.
- RESET asserted in SERVICE with HLDA = 1 → next edge HRQ = 0, DACK = 4'hF, state IDLE. With DMA_DREQ_SYNC_EN defined, DREQ-to-HRQ latency measures 3 cycles.
